// File: rtl/mnist_seq_pkg.sv
// Shared definitions for the MNIST job sequencer: FSM states, register
// offsets within the 8 KiB window, and STATUS bit positions.
package mnist_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KICK = 3'd1,
    ST_WAIT = 3'd2,
    ST_SCAN = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } seq_state_t;

  localparam logic [12:0] OFF_CTRL     = 13'h0000;
  localparam logic [12:0] OFF_STATUS   = 13'h0004;
  localparam logic [12:0] OFF_CLASS    = 13'h0008;
  localparam logic [12:0] OFF_MAX      = 13'h000C;
  localparam logic [12:0] OFF_CYCLES   = 13'h0010;
  localparam logic [12:0] OFF_IMG_BASE = 13'h1000;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;

  function automatic logic state_is_busy(input seq_state_t s);
    return (s == ST_KICK) || (s == ST_WAIT) || (s == ST_SCAN);
  endfunction

endpackage

// File: rtl/argmax_unit.sv
// Sequential signed maximum tracker. A valid sample with clear loads the
// winner unconditionally; later samples replace it only when strictly greater.
module argmax_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [3:0]  i_index,
  input  logic [31:0] i_score,
  output logic [31:0] o_max,
  output logic [3:0]  o_class
);

  logic [31:0] r_max;
  logic [3:0]  r_class;

  // Track the running winner; strict compare keeps ties at the lowest index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_max   <= 32'd0;
      r_class <= 4'd0;
    end else if (i_valid && (i_clear || ($signed(i_score) > $signed(r_max)))) begin
      r_max   <= i_score;
      r_class <= i_index;
    end else if (i_clear) begin
      r_max   <= 32'd0;
      r_class <= 4'd0;
    end
  end

  assign o_max   = r_max;
  assign o_class = r_class;

endmodule

// File: rtl/mnist_job_sequencer.sv
// Memory-mapped job controller between the picoRV32 native bus and the MNIST
// accelerator: image loading, accelerator reset/wait, argmax scan and readback.
module mnist_job_sequencer
  import mnist_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          N_PIX      = 785,
  parameter int          N_CLASS    = 10,
  parameter int          RST_CYCLES = 2,
  parameter int          TIMEOUT    = 200000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        img_we,
  output logic [9:0]  img_idx,
  output logic [31:0] img_data,
  output logic        acc_reset,
  input  logic        acc_ready,
  output logic [3:0]  acc_sel,
  input  logic [31:0] acc_result,
  output logic        irq
);

  localparam logic [10:0] LP_N_PIX    = 11'(N_PIX);
  localparam logic [15:0] LP_RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [31:0] LP_WAIT_LAST = 32'(TIMEOUT - 1);
  localparam logic [3:0]  LP_SEL_LAST = 4'(N_CLASS - 1);

  seq_state_t  r_state;
  logic        r_mem_ready;
  logic [31:0] r_mem_rdata;
  logic        r_img_we;
  logic [9:0]  r_img_idx;
  logic [31:0] r_img_data;
  logic        r_acc_reset;
  logic [3:0]  r_sel;
  logic        r_irq;
  logic        r_done;
  logic        r_timeout;
  logic        r_seen_low;
  logic [15:0] r_rst_cnt;
  logic [31:0] r_wait_cnt;
  logic [31:0] r_cycles;

  logic [31:0] w_offset;
  logic [12:0] w_off13;
  logic        w_hit;
  logic        w_accept;
  logic        w_write;
  logic        w_busy;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_clear;
  logic [9:0]  w_img_idx;
  logic        w_img_ok;
  logic        w_scan_valid;
  logic        w_scan_clear;
  logic [31:0] w_max;
  logic [3:0]  w_class;
  logic [31:0] w_rdata;

  // Offsets below BASE_ADDR wrap to large values, so one unsigned compare covers both bounds.
  assign w_offset  = mem_addr - BASE_ADDR;
  assign w_off13   = w_offset[12:0];
  assign w_hit     = mem_valid && (w_offset < 32'h0000_2000);
  assign w_accept  = w_hit && !r_mem_ready;
  assign w_write   = (mem_wstrb != 4'b0000);
  assign w_busy    = state_is_busy(r_state);
  assign w_ctrl_wr = w_accept && w_write && (w_off13 == OFF_CTRL);
  assign w_start   = w_ctrl_wr && mem_wdata[0];
  assign w_clear   = w_ctrl_wr && mem_wdata[1];
  assign w_img_idx = w_off13[11:2];
  assign w_img_ok  = w_accept && w_write && w_off13[12] && !w_busy &&
                     ({1'b0, w_img_idx} < LP_N_PIX);

  assign w_scan_valid = (r_state == ST_SCAN);
  assign w_scan_clear = w_scan_valid && (r_sel == 4'd0);

  argmax_unit u_argmax (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_clear (w_scan_clear),
    .i_valid (w_scan_valid),
    .i_index (r_sel),
    .i_score (acc_result),
    .o_max   (w_max),
    .o_class (w_class)
  );

  // Readback mux; writes and unmapped offsets return zero.
  always_comb begin
    w_rdata = 32'd0;
    if (w_write) begin
      w_rdata = 32'd0;
    end else begin
      case (w_off13)
        OFF_STATUS: begin
          w_rdata[STAT_BUSY]    = w_busy;
          w_rdata[STAT_DONE]    = r_done;
          w_rdata[STAT_TIMEOUT] = r_timeout;
        end
        OFF_CLASS:  w_rdata = {28'd0, w_class};
        OFF_MAX:    w_rdata = w_max;
        OFF_CYCLES: w_rdata = r_cycles;
        default:    w_rdata = 32'd0;
      endcase
    end
  end

  // Bus slave: single-cycle ack, read data and image write strobe all registered together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_ready <= 1'b0;
      r_mem_rdata <= 32'd0;
      r_img_we    <= 1'b0;
      r_img_idx   <= 10'd0;
      r_img_data  <= 32'd0;
    end else begin
      r_mem_ready <= w_accept;
      r_mem_rdata <= w_accept ? w_rdata : 32'd0;
      r_img_we    <= w_img_ok;
      if (w_img_ok) begin
        r_img_idx  <= w_img_idx;
        r_img_data <= mem_wdata;
      end
    end
  end

  // Job FSM; irq and the done/timeout flags are raised on the transition into DONE/ERR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_acc_reset <= 1'b0;
      r_sel       <= 4'd0;
      r_irq       <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_seen_low  <= 1'b0;
      r_rst_cnt   <= 16'd0;
      r_wait_cnt  <= 32'd0;
      r_cycles    <= 32'd0;
    end else begin
      r_irq <= 1'b0;
      if (w_busy && (r_cycles != 32'hFFFF_FFFF)) begin
        r_cycles <= r_cycles + 32'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_KICK;
            r_acc_reset <= 1'b1;
            r_rst_cnt   <= 16'd0;
            r_seen_low  <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cycles    <= 32'd0;
          end else if (w_clear) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        ST_KICK: begin
          if (!acc_ready) begin
            r_seen_low <= 1'b1;
          end
          if (r_rst_cnt == LP_RST_LAST) begin
            r_state     <= ST_WAIT;
            r_acc_reset <= 1'b0;
            r_wait_cnt  <= 32'd0;
          end else begin
            r_rst_cnt <= r_rst_cnt + 16'd1;
          end
        end
        ST_WAIT: begin
          // Ready only counts once a low has been seen, so a stale high is ignored.
          if (acc_ready && r_seen_low) begin
            r_state <= ST_SCAN;
            r_sel   <= 4'd0;
          end else if (r_wait_cnt == LP_WAIT_LAST) begin
            r_state   <= ST_ERR;
            r_timeout <= 1'b1;
            r_irq     <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
            if (!acc_ready) begin
              r_seen_low <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (r_sel == LP_SEL_LAST) begin
            r_state <= ST_DONE;
            r_sel   <= 4'd0;
            r_done  <= 1'b1;
            r_irq   <= 1'b1;
          end else begin
            r_sel <= r_sel + 4'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_ready = r_mem_ready;
  assign mem_rdata = r_mem_rdata;
  assign img_we    = r_img_we;
  assign img_idx   = r_img_idx;
  assign img_data  = r_img_data;
  assign acc_reset = r_acc_reset;
  assign acc_sel   = r_sel;
  assign irq       = r_irq;

endmodule

// File: tb/tb_mnist_job_sequencer.sv
// Self-checking bench for mnist_job_sequencer: table-driven bus vectors plus
// job sequences checked against a score-table argmax and cycle-count model.
module tb_mnist_job_sequencer;

  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam int          TMO  = 100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        img_we;
  logic [9:0]  img_idx;
  logic [31:0] img_data;
  logic        acc_reset;
  logic        acc_ready;
  logic [3:0]  acc_sel;
  logic [31:0] acc_result;
  logic        irq;

  logic signed [31:0] scores [16];
  assign acc_result = scores[acc_sel];

  always #5 clk = ~clk;

  mnist_job_sequencer #(
    .BASE_ADDR(BASE), .N_PIX(785), .N_CLASS(10), .RST_CYCLES(2), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .img_we(img_we), .img_idx(img_idx), .img_data(img_data),
    .acc_reset(acc_reset), .acc_ready(acc_ready), .acc_sel(acc_sel),
    .acc_result(acc_result), .irq(irq)
  );

  int errors = 0;
  int checks = 0;
  int irq_cnt = 0;
  int ar_cnt = 0;

  // Expected CLASS/MAX after the most recent successful job.
  logic [3:0]  model_class;
  logic [31:0] model_max;

  always @(negedge clk) begin
    if (irq === 1'b1) irq_cnt <= irq_cnt + 1;
    if (acc_reset === 1'b1) ar_cnt <= ar_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus request; returns at 1ns after the ack edge (or after the bound expires).
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                          output logic acked, output logic [31:0] rdata, output logic we,
                          output logic [9:0] idx, output logic [31:0] data);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wr ? 4'hF : 4'h0;
    mem_valid = 1'b1;
    acked = 1'b0; rdata = 32'd0; we = 1'b0; idx = 10'd0; data = 32'd0;
    for (int n = 0; n < 8 && !acked; n++) begin
      @(posedge clk);
      #1;
      if (mem_ready === 1'b1) begin
        acked = 1'b1;
        rdata = mem_rdata;
        we    = img_we;
        idx   = img_idx;
        data  = img_data;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                    output logic we);
    logic a; logic [31:0] r; logic [9:0] i; logic [31:0] d;
    bus_xfer(addr, wdata, 1'b1, a, r, we, i, d);
    check({name, "_ack"}, {31'd0, a}, 32'd1);
    tick(1);
    check({name, "_ready_pulse"}, {31'd0, mem_ready}, 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic a; logic [31:0] r; logic w; logic [9:0] i; logic [31:0] d;
    bus_xfer(addr, 32'd0, 1'b0, a, r, w, i, d);
    check({name, "_ack"}, {31'd0, a}, 32'd1);
    check(name, r, exp);
    tick(1);
  endtask

  // Reference argmax: the largest signed score, then its lowest index.
  task automatic model_argmax(output logic [3:0] cls, output logic [31:0] mx);
    int best;
    best = scores[0];
    for (int i = 1; i < 10; i++) if (int'(scores[i]) > best) best = scores[i];
    cls = 4'd0;
    for (int i = 9; i >= 0; i--) if (int'(scores[i]) == best) cls = 4'(i);
    mx = 32'(best);
  endtask

  // Run one job: acc_ready high for `hold` edges after the start ack, then low for
  // `d` edges (d<0: never raised). Ready is accepted at edge max(3, hold+d+1).
  task automatic run_job(input string name, input int hold, input int d, input logic poke);
    logic a; logic [31:0] r; logic w; logic [9:0] i; logic [31:0] dd;
    logic got_irq;
    int irq0, ar0, acc_edge;
    logic [3:0]  exp_cls;
    logic [31:0] exp_max, exp_cyc, exp_stat;
    irq0 = irq_cnt;
    ar0  = ar_cnt;
    acc_ready = (hold > 0);
    bus_xfer(BASE, 32'h0000_0001, 1'b1, a, r, w, i, dd);
    check({name, "_start_ack"}, {31'd0, a}, 32'd1);
    check({name, "_acc_reset_kick"}, {31'd0, acc_reset}, 32'd1);
    tick(hold);
    acc_ready = 1'b0;
    if (d >= 0) begin
      if (poke) begin
        wr({name, "_busy_start"}, BASE, 32'h0000_0001, w);
        wr({name, "_busy_img"}, BASE + 32'h1000, 32'hDEAD_BEEF, w);
        check({name, "_busy_img_we"}, {31'd0, w}, 32'd0);
        rd_chk({name, "_busy_status"}, BASE + 32'h4, 32'h1);
        tick(d - 6);
      end else begin
        tick(d);
      end
      acc_ready = 1'b1;
    end
    got_irq = 1'b0;
    for (int n = 0; n < 400 && !got_irq; n++) begin
      @(posedge clk);
      #1;
      if (irq === 1'b1) got_irq = 1'b1;
    end
    check({name, "_irq_seen"}, {31'd0, got_irq}, 32'd1);
    tick(2);
    if (d < 0) begin
      exp_cyc  = 32'(2 + TMO);
      exp_stat = 32'h4;
    end else begin
      acc_edge = (hold + d + 1 > 3) ? hold + d + 1 : 3;
      exp_cyc  = 32'(acc_edge + 10);
      exp_stat = 32'h2;
      model_argmax(exp_cls, exp_max);
      model_class = exp_cls;
      model_max   = exp_max;
    end
    check({name, "_irq_count"}, 32'(irq_cnt - irq0), 32'd1);
    check({name, "_acc_reset_cycles"}, 32'(ar_cnt - ar0), 32'd2);
    rd_chk({name, "_status"}, BASE + 32'h4, exp_stat);
    rd_chk({name, "_class"}, BASE + 32'h8, {28'd0, model_class});
    rd_chk({name, "_max"}, BASE + 32'hC, model_max);
    rd_chk({name, "_cycles"}, BASE + 32'h10, exp_cyc);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        is_wr;
    logic        exp_ack;
    logic        exp_we;
    logic [9:0]  exp_idx;
    logic [31:0] exp_data;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic a; logic [31:0] r; logic w; logic [9:0] ix; logic [31:0] dd;
    mem_valid = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'h0;
    acc_ready = 1'b0; resetn = 1'b0;
    model_class = 4'd0; model_max = 32'd0;
    for (int k = 0; k < 16; k++) scores[k] = 32'sd0;

    vecs[0]  = '{BASE + 32'h1000, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 10'd0,   32'h1234_5678, 32'd0};
    vecs[1]  = '{BASE + 32'h1C40, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 10'd784, 32'h1234_5678, 32'd0};
    vecs[2]  = '{BASE + 32'h1C44, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 10'd0,   32'd0,         32'd0};
    vecs[3]  = '{BASE + 32'h1010, 32'hA5A5_0F0F, 1'b1, 1'b1, 1'b1, 10'd4,   32'hA5A5_0F0F, 32'd0};
    vecs[4]  = '{BASE + 32'h0004, 32'd0,         1'b0, 1'b1, 1'b0, 10'd0,   32'd0,         32'd0};
    vecs[5]  = '{BASE + 32'h0008, 32'd0,         1'b0, 1'b1, 1'b0, 10'd0,   32'd0,         32'd0};
    vecs[6]  = '{BASE + 32'h000C, 32'd0,         1'b0, 1'b1, 1'b0, 10'd0,   32'd0,         32'd0};
    vecs[7]  = '{BASE + 32'h0010, 32'd0,         1'b0, 1'b1, 1'b0, 10'd0,   32'd0,         32'd0};
    vecs[8]  = '{BASE + 32'h0000, 32'd0,         1'b0, 1'b1, 1'b0, 10'd0,   32'd0,         32'd0};
    vecs[9]  = '{BASE + 32'h0100, 32'd0,         1'b0, 1'b1, 1'b0, 10'd0,   32'd0,         32'd0};
    vecs[10] = '{BASE + 32'h2000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 10'd0,   32'd0,         32'd0};
    vecs[11] = '{BASE - 32'h4,    32'd0,         1'b0, 1'b0, 1'b0, 10'd0,   32'd0,         32'd0};
    vecs[12] = '{BASE + 32'h0040, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 10'd0,   32'd0,         32'd0};

    tick(2);
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_acc_reset", {31'd0, acc_reset}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    resetn = 1'b1;
    tick(2);

    for (int v = 0; v < 13; v++) begin
      bus_xfer(vecs[v].addr, vecs[v].wdata, vecs[v].is_wr, a, r, w, ix, dd);
      check($sformatf("vec%0d_ack", v), {31'd0, a}, {31'd0, vecs[v].exp_ack});
      if (vecs[v].exp_ack) begin
        check($sformatf("vec%0d_we", v), {31'd0, w}, {31'd0, vecs[v].exp_we});
        if (vecs[v].exp_we) begin
          check($sformatf("vec%0d_idx", v), {22'd0, ix}, {22'd0, vecs[v].exp_idx});
          check($sformatf("vec%0d_data", v), dd, vecs[v].exp_data);
        end
        if (!vecs[v].is_wr) check($sformatf("vec%0d_rdata", v), r, vecs[v].exp_rdata);
      end
      tick(1);
      check($sformatf("vec%0d_img_we_low", v), {31'd0, img_we}, 32'd0);
    end

    // Stale ready through KICK, drop, raise 50 cycles later, with busy-time pokes.
    scores[0] = -32'sd5; scores[1] = 32'sd3; scores[2] = 32'sd9; scores[3] = 32'sd9;
    scores[4] = -32'sd1; scores[5] = 32'sd0; scores[6] = 32'sd2; scores[7] = 32'sd7;
    scores[8] = 32'sd1;  scores[9] = 32'sd4;
    run_job("job_ties", 4, 50, 1'b1);
    check("job_ties_class_const", {28'd0, model_class}, 32'd2);

    wr("clear", BASE, 32'h0000_0002, w);
    rd_chk("clear_status", BASE + 32'h4, 32'h0);

    scores[0] = -32'sd100; scores[1] = -32'sd90; scores[2] = -32'sd80; scores[3] = -32'sd70;
    scores[4] = -32'sd50;  scores[5] = -32'sd20; scores[6] = -32'sd3;  scores[7] = -32'sd10;
    scores[8] = -32'sd4;   scores[9] = -32'sd30;
    run_job("job_neg", 0, 5, 1'b0);
    check("job_neg_max_const", model_max, 32'hFFFF_FFFD);

    run_job("job_timeout", 0, -1, 1'b0);

    // Reset asserted during KICK: outputs drop immediately, next job is normal.
    acc_ready = 1'b0;
    bus_xfer(BASE, 32'h0000_0001, 1'b1, a, r, w, ix, dd);
    check("mid_rst_start_ack", {31'd0, a}, 32'd1);
    check("mid_rst_acc_reset_before", {31'd0, acc_reset}, 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_acc_reset", {31'd0, acc_reset}, 32'd0);
    check("mid_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    check("mid_rst_acc_sel", {28'd0, acc_sel}, 32'd0);
    check("mid_rst_img", {img_we, img_idx, img_data[20:0]}, 32'd0);
    tick(2);
    resetn = 1'b1;
    model_class = 4'd0;
    model_max   = 32'd0;
    tick(2);
    rd_chk("post_rst_status", BASE + 32'h4, 32'h0);
    rd_chk("post_rst_class", BASE + 32'h8, 32'h0);
    rd_chk("post_rst_cycles", BASE + 32'h10, 32'h0);

    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 10; k++) begin
        if (j[0]) scores[k] = $signed(32'($urandom_range(0, 6)) - 32'd3);
        else      scores[k] = $signed($urandom);
      end
      run_job($sformatf("rand%0d", j), int'($urandom_range(0, 3)), int'($urandom_range(2, 40)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
